// File: rtl/ld_frame_parser.sv
// Radar byte-stream frame parser: validates 55 A5 D_HI D_LO S_HI S_LO CHK frames
// and publishes distance/speed, with inter-byte and data-freshness timeouts.
module ld_frame_parser #(
    parameter int unsigned BYTE_TIMEOUT  = 50000,
    parameter int unsigned STALE_TIMEOUT = 25000000,
    parameter logic [7:0]  HDR0          = 8'h55,
    parameter logic [7:0]  HDR1          = 8'hA5
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        i_en,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_vld,
    output logic [19:0] o_jl_data,
    output logic [19:0] o_sd_data,
    output logic        o_data_vld,
    output logic        o_frame_err,
    output logic [7:0]  o_err_cnt,
    output logic        o_stale
);

    localparam int unsigned BW = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(STALE_TIMEOUT + 1);
    localparam logic [BW-1:0] BYTE_LIM  = BW'(BYTE_TIMEOUT - 1);
    localparam logic [SW-1:0] STALE_LIM = SW'(STALE_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_CHK  = 2'd3;

    logic [1:0]      state_q, state_nxt;
    logic [1:0]      idx_q, idx_nxt;
    logic [7:0]      sum_q, sum_nxt;
    logic [3:0][7:0] pay_q, pay_nxt;
    logic [BW-1:0]   bcnt_q, bcnt_nxt;
    logic [SW-1:0]   scnt_q;
    logic            good_c;
    logic            bad_c;
    logic            tmo_c;
    logic            rx_c;

    assign rx_c = i_en & i_rx_vld;

    // Parser state, payload buffer, running checksum and byte-gap counter
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            sum_q   <= 8'd0;
            pay_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            sum_q   <= sum_nxt;
            pay_q   <= pay_nxt;
            bcnt_q  <= bcnt_nxt;
        end
    end

    // Next-state decode; an arriving byte always beats the inter-byte timeout
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        sum_nxt   = sum_q;
        pay_nxt   = pay_q;
        bcnt_nxt  = bcnt_q;
        good_c    = 1'b0;
        bad_c     = 1'b0;
        tmo_c     = 1'b0;
        if (!i_en) begin
            state_nxt = ST_IDLE;
            bcnt_nxt  = '0;
        end else if (rx_c) begin
            bcnt_nxt = '0;
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_data == HDR0) state_nxt = ST_HDR;
                end
                ST_HDR: begin
                    if (i_rx_data == HDR1) begin
                        state_nxt = ST_PAY;
                        idx_nxt   = 2'd0;
                        sum_nxt   = 8'd0;
                    end else if (i_rx_data != HDR0) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_PAY: begin
                    pay_nxt[idx_q] = i_rx_data;
                    sum_nxt        = sum_q + i_rx_data;
                    idx_nxt        = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_nxt = ST_CHK;
                end
                ST_CHK: begin
                    good_c    = (i_rx_data == sum_q);
                    bad_c     = (i_rx_data != sum_q);
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (bcnt_q == BYTE_LIM) begin
                tmo_c     = 1'b1;
                state_nxt = ST_IDLE;
                bcnt_nxt  = '0;
            end else begin
                bcnt_nxt = bcnt_q + BW'(1);
            end
        end
    end

    // Published data, pulses, error count and freshness tracking
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            o_jl_data   <= 20'd0;
            o_sd_data   <= 20'd0;
            o_data_vld  <= 1'b0;
            o_frame_err <= 1'b0;
            o_err_cnt   <= 8'd0;
            o_stale     <= 1'b1;
            scnt_q      <= '0;
        end else begin
            o_data_vld  <= good_c;
            o_frame_err <= bad_c | tmo_c;
            if ((bad_c || tmo_c) && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
            if (good_c) begin
                o_jl_data <= {4'd0, pay_q[0], pay_q[1]};
                o_sd_data <= {4'd0, pay_q[2], pay_q[3]};
                o_stale   <= 1'b0;
                scnt_q    <= '0;
            end else if (scnt_q == STALE_LIM) begin
                o_stale   <= 1'b1;
                o_jl_data <= 20'd0;
                o_sd_data <= 20'd0;
            end else begin
                scnt_q <= scnt_q + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ld_frame_parser.sv
// Directed bench for ld_frame_parser with shortened timeouts.
module tb_ld_frame_parser;

    localparam int unsigned BT = 32;
    localparam int unsigned ST = 400;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        i_en;
    logic [7:0]  i_rx_data;
    logic        i_rx_vld;
    logic [19:0] o_jl_data;
    logic [19:0] o_sd_data;
    logic        o_data_vld;
    logic        o_frame_err;
    logic [7:0]  o_err_cnt;
    logic        o_stale;

    int n_cmp = 0;
    int n_err = 0;

    ld_frame_parser #(.BYTE_TIMEOUT(BT), .STALE_TIMEOUT(ST)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .i_en        (i_en),
        .i_rx_data   (i_rx_data),
        .i_rx_vld    (i_rx_vld),
        .o_jl_data   (o_jl_data),
        .o_sd_data   (o_sd_data),
        .o_data_vld  (o_data_vld),
        .o_frame_err (o_frame_err),
        .o_err_cnt   (o_err_cnt),
        .o_stale     (o_stale)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Presents one byte for exactly one cycle; returns 1 time unit after the capturing edge
    task automatic send(input logic [7:0] b);
        i_rx_data = b;
        i_rx_vld  = 1'b1;
        @(posedge sys_clk);
        #1;
        i_rx_vld  = 1'b0;
    endtask

    task automatic frame(input logic [7:0] dh, input logic [7:0] dl,
                         input logic [7:0] sh, input logic [7:0] sl, input logic [7:0] ck);
        send(8'h55); send(8'hA5); send(dh); send(dl); send(sh); send(sl); send(ck);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        i_en      = 1'b0;
        i_rx_data = 8'h00;
        i_rx_vld  = 1'b0;
        #12;
        check("rst_jl", 32'(o_jl_data), 32'd0);
        check("rst_sd", 32'(o_sd_data), 32'd0);
        check("rst_vld", 32'(o_data_vld), 32'd0);
        check("rst_ferr", 32'(o_frame_err), 32'd0);
        check("rst_errcnt", 32'(o_err_cnt), 32'd0);
        check("rst_stale", 32'(o_stale), 32'd1);
        sys_rst_n = 1'b1;
        tick(1);
        i_en = 1'b1;
        tick(1);

        // Good frame: distance 30, speed 12
        frame(8'h00, 8'h1E, 8'h00, 8'h0C, 8'h2A);
        check("good_vld", 32'(o_data_vld), 32'd1);
        check("good_jl", 32'(o_jl_data), 32'd30);
        check("good_sd", 32'(o_sd_data), 32'd12);
        check("good_stale", 32'(o_stale), 32'd0);
        check("good_errcnt", 32'(o_err_cnt), 32'd0);
        check("good_ferr", 32'(o_frame_err), 32'd0);
        tick(1);
        check("good_vld_pulse", 32'(o_data_vld), 32'd0);

        // Bad checksum: error pulse, data held
        frame(8'h00, 8'h1E, 8'h00, 8'h0C, 8'h2B);
        check("badck_ferr", 32'(o_frame_err), 32'd1);
        check("badck_vld", 32'(o_data_vld), 32'd0);
        check("badck_errcnt", 32'(o_err_cnt), 32'd1);
        check("badck_jl", 32'(o_jl_data), 32'd30);
        check("badck_sd", 32'(o_sd_data), 32'd12);
        tick(1);
        check("badck_ferr_pulse", 32'(o_frame_err), 32'd0);

        // Resync on repeated header and leading junk
        send(8'h12); send(8'h55); send(8'h55); send(8'hA5);
        send(8'h01); send(8'h2C); send(8'h00); send(8'h05); send(8'h32);
        check("resync_vld", 32'(o_data_vld), 32'd1);
        check("resync_jl", 32'(o_jl_data), 32'd300);
        check("resync_sd", 32'(o_sd_data), 32'd5);
        check("resync_errcnt", 32'(o_err_cnt), 32'd1);

        // Back-to-back frame with zero gap
        frame(8'h00, 8'h64, 8'h00, 8'h07, 8'h6B);
        check("b2b_vld", 32'(o_data_vld), 32'd1);
        check("b2b_jl", 32'(o_jl_data), 32'd100);
        check("b2b_sd", 32'(o_sd_data), 32'd7);

        // Byte arriving on the timeout-limit cycle wins
        send(8'h55); send(8'hA5);
        tick(BT - 1);
        send(8'h00);
        check("edge_ferr", 32'(o_frame_err), 32'd0);
        send(8'h1E); send(8'h00); send(8'h0C); send(8'h2A);
        check("edge_vld", 32'(o_data_vld), 32'd1);
        check("edge_jl", 32'(o_jl_data), 32'd30);
        check("edge_errcnt", 32'(o_err_cnt), 32'd1);

        // Inter-byte timeout mid-frame
        send(8'h55); send(8'hA5); send(8'h00);
        tick(BT - 1);
        check("tmo_early", 32'(o_frame_err), 32'd0);
        tick(1);
        check("tmo_ferr", 32'(o_frame_err), 32'd1);
        check("tmo_errcnt", 32'(o_err_cnt), 32'd2);
        frame(8'h00, 8'h0C, 8'h00, 8'h03, 8'h0F);
        check("tmo_next_vld", 32'(o_data_vld), 32'd1);
        check("tmo_next_jl", 32'(o_jl_data), 32'd12);
        check("tmo_next_sd", 32'(o_sd_data), 32'd3);

        // Staleness after STALE_TIMEOUT cycles of silence
        tick(ST - 1);
        check("stale_early", 32'(o_stale), 32'd0);
        check("stale_early_jl", 32'(o_jl_data), 32'd12);
        tick(1);
        check("stale_set", 32'(o_stale), 32'd1);
        check("stale_jl", 32'(o_jl_data), 32'd0);
        check("stale_sd", 32'(o_sd_data), 32'd0);
        frame(8'h00, 8'h1E, 8'h00, 8'h0C, 8'h2A);
        check("stale_clear", 32'(o_stale), 32'd0);
        check("stale_new_jl", 32'(o_jl_data), 32'd30);

        // Enable dropped mid-frame, including the checksum cycle
        send(8'h55); send(8'hA5); send(8'h00); send(8'h1E);
        i_en = 1'b0;
        send(8'h00); send(8'h0C); send(8'h2A);
        check("en_vld", 32'(o_data_vld), 32'd0);
        check("en_ferr", 32'(o_frame_err), 32'd0);
        check("en_errcnt", 32'(o_err_cnt), 32'd2);
        i_en = 1'b1;
        send(8'h0C); send(8'h2A);
        check("en_partial_vld", 32'(o_data_vld), 32'd0);
        frame(8'h00, 8'h05, 8'h00, 8'h01, 8'h06);
        check("en_after_jl", 32'(o_jl_data), 32'd5);
        check("en_after_sd", 32'(o_sd_data), 32'd1);

        // Error counter saturation
        for (int i = 0; i < 252; i++) frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
        check("sat_254", 32'(o_err_cnt), 32'd254);
        for (int i = 0; i < 4; i++) frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
        check("sat_255", 32'(o_err_cnt), 32'd255);

        // Asynchronous reset mid-frame
        frame(8'h00, 8'h1E, 8'h00, 8'h0C, 8'h2A);
        send(8'h55); send(8'hA5); send(8'h00);
        sys_rst_n = 1'b0;
        #1;
        check("arst_errcnt", 32'(o_err_cnt), 32'd0);
        check("arst_jl", 32'(o_jl_data), 32'd0);
        check("arst_stale", 32'(o_stale), 32'd1);
        sys_rst_n = 1'b1;
        tick(1);
        frame(8'h00, 8'h64, 8'h00, 8'h07, 8'h6B);
        check("arst_next_vld", 32'(o_data_vld), 32'd1);
        check("arst_next_jl", 32'(o_jl_data), 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ld_frame_parser.md
# ld_frame_parser

Byte-stream frame parser for the mmWave radar link. Sits between the radar UART receiver (byte + valid strobe) and the consumers of distance/speed: the proximity alarm, the Kalman filter input and the seven-segment speed/distance display. It validates fixed-format radar frames with a checksum and publishes distance and speed. It enforces inter-byte and data-freshness timeouts, so stale readings cannot hold the alarm on.

## Interface
- BYTE_TIMEOUT, 50000: max sys_clk cycles between bytes inside a frame (1 ms @ 50 MHz)
- STALE_TIMEOUT, 25000000: cycles without a good frame before data is declared stale (0.5 s)
- HDR0, 8'h55: first header byte
- HDR1, 8'hA5: second header byte

- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  receive enable (from radar enable unit)
- i_rx_data  in  8  received byte
- i_rx_vld  in  1  one-cycle strobe, i_rx_data valid
- o_jl_data  out  20  distance, cm, {4'd0, 16-bit}
- o_sd_data  out  20  speed, cm/s, {4'd0, 16-bit}
- o_data_vld  out  1  one-cycle pulse, new good frame published
- o_frame_err  out  1  one-cycle pulse, checksum fail or timeout
- o_err_cnt  out  8  saturating error count
- o_stale  out  1  high while no good frame within STALE_TIMEOUT

## Operation
- Frame: HDR0, HDR1, D_HI, D_LO, S_HI, S_LO, CHK; CHK = (D_HI+D_LO+S_HI+S_LO) mod 256.
- FSM states: IDLE, HDR, PAY (byte index 0..3), CHK.
- IDLE: byte==HDR0 -> HDR; else stay.
- HDR: byte==HDR1 -> PAY idx0; byte==HDR0 -> stay HDR (resync); else -> IDLE, no error.
- PAY: store byte at idx, accumulate 8-bit sum; after idx3 -> CHK.
- CHK: match -> latch o_jl_data={4'd0,D_HI,D_LO}, o_sd_data={4'd0,S_HI,S_LO}, pulse o_data_vld, clear o_stale, restart stale counter; mismatch -> pulse o_frame_err, err_cnt+1, outputs held. Either way -> IDLE.
- Byte timeout: counter cleared on each accepted byte; in any state except IDLE, reaching BYTE_TIMEOUT-1 with no byte -> IDLE, pulse o_frame_err, err_cnt+1.
- Stale: counter runs continuously, cleared only by a good frame; on reaching STALE_TIMEOUT-1 -> o_stale=1, o_jl_data=0, o_sd_data=0 (alarm condition dist>3 then false). Counter holds saturated while stale.
- i_en low: FSM forced to IDLE, partial frame discarded silently, bytes ignored; output registers and stale counter unaffected.
- err_cnt saturates at 255, cleared only by reset.

## Timing
- Reset values: o_jl_data=0, o_sd_data=0, o_data_vld=0, o_frame_err=0, o_err_cnt=0, o_stale=1; FSM IDLE; counters 0.
- Latency: o_jl_data/o_sd_data and o_data_vld update on the edge after the cycle CHK byte has i_rx_vld; data stable when o_data_vld=1.
- o_frame_err for checksum: same edge as would-be o_data_vld; for timeout: edge after counter hits limit.
- Byte and timeout in same cycle: byte wins, counter cleared, no error.
- Good frame and stale limit in same cycle: good frame wins, o_stale=0, new data published.
- i_en falling on CHK-byte cycle: byte ignored, no pulse.
- Back-to-back frames with zero gap supported (HDR0 accepted the cycle after CHK).
- Reset mid-frame: all state to reset values immediately, asynchronously.

## Test plan
- Good frame 55 A5 00 1E 00 0C 2A -> o_data_vld one pulse, o_jl_data=30, o_sd_data=12, o_stale=0, err_cnt=0.
- Same frame with CHK 2B -> o_frame_err pulse, err_cnt=1, o_jl_data/o_sd_data unchanged from previous, no o_data_vld.
- Resync: 12 55 55 A5 01 2C 00 05 32 -> o_jl_data=300, o_sd_data=5, no error.
- Timeout: 55 A5 00, then gap of BYTE_TIMEOUT cycles -> o_frame_err pulse, err_cnt+1; following full good frame accepted normally.
- Stale: good frame (jl=30) then silence STALE_TIMEOUT cycles -> o_stale=1, o_jl_data=0, o_sd_data=0; next good frame clears o_stale.
- i_en=0 during a good frame -> no o_data_vld, no error; 256 bad-checksum frames -> err_cnt saturates at 255.
